// File: rtl/pe_acc_buf.sv
// Per-PE accumulate buffer: aligns AGU commands with MAC results, does per-lane
// read-modify-write accumulation with write-to-read forwarding, and serves a drain port.
module pe_acc_buf #(
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 256,
   parameter int BATCH   = 4,
   parameter int ACC_W   = 32,
   parameter int MAC_LAT = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      abuf_addr,
   input  logic [BATCH-1:0]       abuf_acc_en,
   input  logic                   abuf_acc_new,
   input  logic [BATCH*ACC_W-1:0] mac_res,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic                   rd_rdy,
   output logic                   rd_vld,
   output logic [BATCH*ACC_W-1:0] rd_data,
   output logic                   busy
);

   typedef logic [BATCH-1:0][ACC_W-1:0] vec_t;

   logic [MAC_LAT-1:0][ADDR_W-1:0] dl_addr_q, dl_addr_d;
   logic [MAC_LAT-1:0][BATCH-1:0]  dl_en_q, dl_en_d;
   logic [MAC_LAT-1:0]             dl_new_q, dl_new_d;

   logic [ADDR_W-1:0] s0_addr_q, s0_addr_d, s1_addr_q, s1_addr_d, fwd_addr_q, fwd_addr_d;
   logic [BATCH-1:0]  s0_en_q, s0_en_d, s1_en_q, s1_en_d, fwd_mask_q, fwd_mask_d;
   logic              s0_new_q, s0_new_d, s1_new_q, s1_new_d, fwd_vld_q, fwd_vld_d;
   vec_t              s0_mac_q, s0_mac_d, s1_mac_q, s1_mac_d, s1_old_q, s1_old_d;
   vec_t              fwd_data_q, fwd_data_d, rd_data_q, rd_data_d;
   logic              rd_vld_q, rd_vld_d, rd_rdy_q, rd_rdy_d, busy_q, busy_d;

   vec_t              mem_rd_s, s1_sum_s;
   logic [ADDR_W-1:0] mem_raddr_s;
   logic              s0_cmd_s, s1_cmd_s, fwd_hit_s, rd_acc_s;

   // Read-port arbitration and the S1 per-lane accumulate with forwarding.
   always_comb begin
      s0_cmd_s  = |s0_en_q;
      s1_cmd_s  = |s1_en_q;
      rd_acc_s  = rd_en & rd_rdy_q;
      fwd_hit_s = fwd_vld_q && (fwd_addr_q == s1_addr_q);
      if (s0_cmd_s) begin
         mem_raddr_s = s0_addr_q;
      end else begin
         mem_raddr_s = rd_addr;
      end
      s1_sum_s = s1_mac_q;
      for (int i = 0; i < BATCH; i++) begin
         if (s1_new_q) begin
            s1_sum_s[i] = s1_mac_q[i];
         end else if (fwd_hit_s && fwd_mask_q[i]) begin
            s1_sum_s[i] = fwd_data_q[i] + s1_mac_q[i];
         end else begin
            s1_sum_s[i] = s1_old_q[i] + s1_mac_q[i];
         end
      end
   end

   // Lane-sliced storage gives each lane its own write enable.
   for (genvar g = 0; g < BATCH; g++) begin : g_lane
      logic [ACC_W-1:0] mem_l [DEPTH];

      // Lane RAM write; reads return the pre-write contents.
      always_ff @(posedge clk) begin
         if (s1_cmd_s && s1_en_q[g]) begin
            mem_l[s1_addr_q] <= s1_sum_s[g];
         end
      end

      assign mem_rd_s[g] = mem_l[mem_raddr_s];
   end

   // Next-state for the delay line, pipeline, forwarding register and outputs.
   always_comb begin
      dl_addr_d    = dl_addr_q;
      dl_en_d      = dl_en_q;
      dl_new_d     = dl_new_q;
      dl_addr_d[0] = abuf_addr;
      dl_en_d[0]   = abuf_acc_en;
      dl_new_d[0]  = abuf_acc_new;
      for (int k = 1; k < MAC_LAT; k++) begin
         dl_addr_d[k] = dl_addr_q[k-1];
         dl_en_d[k]   = dl_en_q[k-1];
         dl_new_d[k]  = dl_new_q[k-1];
      end

      s0_addr_d = dl_addr_q[MAC_LAT-1];
      s0_en_d   = dl_en_q[MAC_LAT-1];
      s0_new_d  = dl_new_q[MAC_LAT-1];
      s0_mac_d  = vec_t'(mac_res);

      s1_addr_d = s0_addr_q;
      s1_en_d   = s0_en_q;
      s1_new_d  = s0_new_q;
      s1_mac_d  = s0_mac_q;
      if (s0_cmd_s) begin
         s1_old_d = mem_rd_s;
      end else begin
         s1_old_d = s1_old_q;
      end

      // Cleared on idle cycles so a stale write can never be forwarded.
      fwd_vld_d  = s1_cmd_s;
      fwd_addr_d = s1_addr_q;
      fwd_mask_d = s1_en_q;
      fwd_data_d = s1_sum_s;

      if (rd_acc_s) begin
         rd_data_d = mem_rd_s;
      end else begin
         rd_data_d = rd_data_q;
      end
      rd_vld_d = rd_acc_s;
      rd_rdy_d = ~(|s0_en_d);
      busy_d   = (|dl_en_d) | (|s0_en_d) | (|s1_en_d);
   end

   // State registers; RAM contents are deliberately left out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dl_addr_q  <= {(MAC_LAT*ADDR_W){1'b0}};
         dl_en_q    <= {(MAC_LAT*BATCH){1'b0}};
         dl_new_q   <= {MAC_LAT{1'b0}};
         s0_addr_q  <= {ADDR_W{1'b0}};
         s0_en_q    <= {BATCH{1'b0}};
         s0_new_q   <= 1'b0;
         s0_mac_q   <= {(BATCH*ACC_W){1'b0}};
         s1_addr_q  <= {ADDR_W{1'b0}};
         s1_en_q    <= {BATCH{1'b0}};
         s1_new_q   <= 1'b0;
         s1_mac_q   <= {(BATCH*ACC_W){1'b0}};
         s1_old_q   <= {(BATCH*ACC_W){1'b0}};
         fwd_vld_q  <= 1'b0;
         fwd_addr_q <= {ADDR_W{1'b0}};
         fwd_mask_q <= {BATCH{1'b0}};
         fwd_data_q <= {(BATCH*ACC_W){1'b0}};
         rd_data_q  <= {(BATCH*ACC_W){1'b0}};
         rd_vld_q   <= 1'b0;
         rd_rdy_q   <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         dl_addr_q  <= dl_addr_d;
         dl_en_q    <= dl_en_d;
         dl_new_q   <= dl_new_d;
         s0_addr_q  <= s0_addr_d;
         s0_en_q    <= s0_en_d;
         s0_new_q   <= s0_new_d;
         s0_mac_q   <= s0_mac_d;
         s1_addr_q  <= s1_addr_d;
         s1_en_q    <= s1_en_d;
         s1_new_q   <= s1_new_d;
         s1_mac_q   <= s1_mac_d;
         s1_old_q   <= s1_old_d;
         fwd_vld_q  <= fwd_vld_d;
         fwd_addr_q <= fwd_addr_d;
         fwd_mask_q <= fwd_mask_d;
         fwd_data_q <= fwd_data_d;
         rd_data_q  <= rd_data_d;
         rd_vld_q   <= rd_vld_d;
         rd_rdy_q   <= rd_rdy_d;
         busy_q     <= busy_d;
      end
   end

   assign rd_rdy  = rd_rdy_q;
   assign rd_vld  = rd_vld_q;
   assign rd_data = rd_data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_pe_acc_buf.sv
// Self-checking bench for pe_acc_buf: directed scenarios plus random command bursts
// compared against a sequential per-address accumulate model.
module tb_pe_acc_buf;
   localparam int ADDR_W  = 8;
   localparam int DEPTH   = 256;
   localparam int BATCH   = 4;
   localparam int ACC_W   = 32;
   localparam int MAC_LAT = 3;

   typedef logic [BATCH-1:0][ACC_W-1:0] vec_t;

   logic                   clk;
   logic                   rst;
   logic [ADDR_W-1:0]      abuf_addr;
   logic [BATCH-1:0]       abuf_acc_en;
   logic                   abuf_acc_new;
   logic [BATCH*ACC_W-1:0] mac_res;
   logic                   rd_en;
   logic [ADDR_W-1:0]      rd_addr;
   logic                   rd_rdy;
   logic                   rd_vld;
   logic [BATCH*ACC_W-1:0] rd_data;
   logic                   busy;

   pe_acc_buf #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BATCH(BATCH), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .rst(rst), .abuf_addr(abuf_addr), .abuf_acc_en(abuf_acc_en),
      .abuf_acc_new(abuf_acc_new), .mac_res(mac_res), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_data(rd_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: final contents of each entry if commands were applied one at a time.
   logic [ACC_W-1:0]  mdl [DEPTH][BATCH];
   bit                touched [DEPTH];
   logic [ADDR_W-1:0] c_addr [32];
   logic [BATCH-1:0]  c_en   [32];
   logic              c_new  [32];
   vec_t              c_mac  [32];
   int                n_checks = 0;
   int                n_pass   = 0;

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < BATCH; i++) v[i] = $urandom();
      return v;
   endfunction

   function automatic vec_t mdl_vec(input int a);
      vec_t v;
      for (int i = 0; i < BATCH; i++) v[i] = mdl[a][i];
      return v;
   endfunction

   function automatic vec_t lanes(input logic [ACC_W-1:0] l0, input logic [ACC_W-1:0] l1,
                                  input logic [ACC_W-1:0] l2, input logic [ACC_W-1:0] l3);
      vec_t v;
      v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
      return v;
   endfunction

   task automatic set_cmd(input int k, input logic [ADDR_W-1:0] a, input logic [BATCH-1:0] en,
                          input logic nw, input vec_t mac);
      c_addr[k] = a; c_en[k] = en; c_new[k] = nw; c_mac[k] = mac;
      for (int i = 0; i < BATCH; i++)
         if (en[i]) mdl[a][i] = (nw ? 32'd0 : mdl[a][i]) + mac[i];
      if (en != 4'b0000) touched[a] = 1'b1;
   endtask

   // Commands on consecutive cycles, each MAC result MAC_LAT cycles after its command.
   task automatic issue_seq(input int n);
      for (int k = 0; k < n + MAC_LAT; k++) begin
         @(negedge clk);
         if (k < n) begin
            abuf_addr = c_addr[k]; abuf_acc_en = c_en[k]; abuf_acc_new = c_new[k];
         end else begin
            abuf_addr = 8'd0; abuf_acc_en = 4'b0000; abuf_acc_new = 1'b0;
         end
         if (k >= MAC_LAT) mac_res = c_mac[k-MAC_LAT];
         else mac_res = rand_vec();
      end
      @(negedge clk);
      abuf_acc_en = 4'b0000;
      mac_res = rand_vec();
   endtask

   task automatic wait_idle(input string name);
      bit idle = 1'b0;
      for (int w = 0; w < 40; w++) begin
         if (busy === 1'b0) begin idle = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!idle) $display("FAIL %s_idle busy still %b after 40 cycles, want 0", name, busy);
      else n_pass++;
   endtask

   task automatic drain(input int a, input string name);
      bit acc = 1'b0;
      vec_t exp_v;
      exp_v = mdl_vec(a);
      @(negedge clk);
      rd_en = 1'b1; rd_addr = ADDR_W'(a);
      for (int w = 0; w < 10 && !acc; w++) begin
         if (rd_rdy === 1'b1) begin
            acc = 1'b1;
            n_checks++;
            if (rd_vld !== 1'b0) $display("FAIL %s_vld_early rd_vld=%b want 0", name, rd_vld);
            else n_pass++;
         end
         @(negedge clk);
      end
      rd_en = 1'b0;
      n_checks++;
      if (!acc || rd_vld !== 1'b1) $display("FAIL %s_vld accepted=%b rd_vld=%b want 1", name, acc, rd_vld);
      else n_pass++;
      n_checks++;
      if (rd_data !== exp_v) $display("FAIL %s_data got %h want %h", name, rd_data, exp_v);
      else n_pass++;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
         n_checks++; if (rd_rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", rd_rdy); else n_pass++;
         n_checks++; if (rd_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", rd_vld); else n_pass++;
         n_checks++; if (rd_data !== 128'd0) $display("FAIL reset_data got %h want 0", rd_data); else n_pass++;
         rst = 1'b1;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_single_new();
      set_cmd(0, 8'd5, 4'b1111, 1'b1, lanes(32'd1, 32'd2, 32'd3, 32'd4));
      issue_seq(1);
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_s0 got %b want 1", busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_s1 got %b want 1", busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_fall got %b want 0", busy); else n_pass++;
      drain(5, "single");
      @(negedge clk);
      n_checks++; if (rd_vld !== 1'b0) $display("FAIL single_vld_pulse got %b want 0", rd_vld); else n_pass++;
      n_checks++;
      if (rd_data !== lanes(32'd1, 32'd2, 32'd3, 32'd4))
         $display("FAIL single_hold got %h want lanes 1,2,3,4", rd_data);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++)
         set_cmd(k, 8'd7, 4'b1111, (k == 0), lanes(32'd10, 32'd10, 32'd10, 32'd10));
      issue_seq(4);
      wait_idle("b2b");
      drain(7, "b2b");
   endtask

   task automatic test_lane_mask();
      set_cmd(0, 8'd3, 4'b1111, 1'b1, lanes(32'd5, 32'd5, 32'd5, 32'd5));
      issue_seq(1);
      wait_idle("mask_preset");
      set_cmd(0, 8'd3, 4'b0101, 1'b0, lanes(32'd1, 32'd1, 32'd1, 32'd1));
      issue_seq(1);
      wait_idle("mask");
      drain(3, "mask");
   endtask

   task automatic test_wrap();
      set_cmd(0, 8'd11, 4'b1111, 1'b1, lanes(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF));
      set_cmd(1, 8'd11, 4'b1111, 1'b0, lanes(32'd1, 32'd1, 32'd1, 32'h80000001));
      issue_seq(2);
      wait_idle("wrap");
      drain(11, "wrap");
   endtask

   task automatic test_arbitration();
      vec_t exp5;
      exp5 = mdl_vec(5);
      set_cmd(0, 8'd12, 4'b1111, 1'b1, rand_vec());
      @(negedge clk);
      abuf_addr = 8'd12; abuf_acc_en = 4'b1111; abuf_acc_new = 1'b1; mac_res = rand_vec();
      for (int k = 1; k <= MAC_LAT; k++) begin
         @(negedge clk);
         abuf_acc_en = 4'b0000; abuf_acc_new = 1'b0;
         if (k == MAC_LAT) mac_res = c_mac[0];
      end
      n_checks++; if (rd_rdy !== 1'b1) $display("FAIL arb_rdy_before got %b want 1", rd_rdy); else n_pass++;
      @(negedge clk);
      mac_res = rand_vec();
      rd_en = 1'b1; rd_addr = 8'd5;
      n_checks++; if (rd_rdy !== 1'b0) $display("FAIL arb_rdy_s0 got %b want 0", rd_rdy); else n_pass++;
      @(negedge clk);
      n_checks++; if (rd_vld !== 1'b0) $display("FAIL arb_refused_vld got %b want 0", rd_vld); else n_pass++;
      n_checks++; if (rd_rdy !== 1'b1) $display("FAIL arb_rdy_after got %b want 1", rd_rdy); else n_pass++;
      @(negedge clk);
      rd_en = 1'b0;
      n_checks++; if (rd_vld !== 1'b1) $display("FAIL arb_vld got %b want 1", rd_vld); else n_pass++;
      n_checks++; if (rd_data !== exp5) $display("FAIL arb_data got %h want %h", rd_data, exp5); else n_pass++;
      wait_idle("arb");
      drain(12, "arb_cmd");
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 16; k++) begin
            logic [ADDR_W-1:0] a;
            logic [BATCH-1:0]  en;
            logic              nw;
            a  = ADDR_W'(16 + $urandom_range(0, 5));
            en = ($urandom_range(0, 4) == 0) ? 4'b0000 : BATCH'($urandom_range(1, 15));
            nw = ($urandom_range(0, 3) == 0);
            if (en != 4'b0000 && !touched[a]) begin en = 4'b1111; nw = 1'b1; end
            set_cmd(k, a, en, nw, rand_vec());
         end
         issue_seq(16);
         wait_idle("rand");
      end
      for (int a = 16; a < 22; a++)
         if (touched[a]) drain(a, "rand");
   endtask

   task automatic test_reset_mid();
      set_cmd(0, 8'd9, 4'b1111, 1'b1, rand_vec());
      issue_seq(1);
      wait_idle("rmid_preset");
      drain(9, "rmid_preset");
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         abuf_addr = 8'd9; abuf_acc_en = 4'b1111; abuf_acc_new = 1'b0; mac_res = rand_vec();
      end
      @(posedge clk);
      #2;
      n_checks++; if (busy !== 1'b1) $display("FAIL rmid_busy_before got %b want 1", busy); else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (rd_vld !== 1'b0) $display("FAIL rmid_vld got %b want 0", rd_vld); else n_pass++;
      n_checks++; if (rd_data !== 128'd0) $display("FAIL rmid_data got %h want 0", rd_data); else n_pass++;
      n_checks++; if (rd_rdy !== 1'b1) $display("FAIL rmid_rdy got %b want 1", rd_rdy); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         abuf_addr = 8'd9; abuf_acc_en = 4'b1111; abuf_acc_new = 1'b0; mac_res = rand_vec();
      end
      @(negedge clk);
      rst = 1'b1; abuf_acc_en = 4'b0000;
      for (int k = 0; k < MAC_LAT + 3; k++) begin
         @(negedge clk);
         mac_res = rand_vec();
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy_after got %b want 0", busy); else n_pass++;
      drain(9, "rmid");
   endtask

   initial begin
      rst = 1'b1;
      abuf_addr = 8'd0; abuf_acc_en = 4'b0000; abuf_acc_new = 1'b0;
      mac_res = 128'd0; rd_en = 1'b0; rd_addr = 8'd0;
      #2 rst = 1'b0;
      test_reset();
      test_single_new();
      test_back_to_back();
      test_lane_mask();
      test_wrap();
      test_arbitration();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pe_acc_buf.md
Name: pe_acc_buf

Overview:
- Per-PE accumulate buffer, directly downstream of the PE address-generation unit.
- Consumes the AGU accumulate command stream (abuf_addr, abuf_acc_en, abuf_acc_new) and the MAC array result vector.
- Performs per-lane read-modify-write accumulation into a BATCH-lane RAM, with hazard forwarding.
- Provides a handshaked drain port the PE output stage uses to read finished partial sums.

Parameters:
ADDR_W, 8, accumulate buffer address width
DEPTH, 256, number of entries (at most 2^ADDR_W)
BATCH, GLOBAL_PARAM::BATCH, lanes per entry
ACC_W, 32, accumulator width per lane (two's complement)
MAC_LAT, 3, cycles from AGU command to matching mac_res (at least 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
abuf_addr  in  ADDR_W  AGU accumulate address
abuf_acc_en  in  BATCH  per-lane accumulate enable; a nonzero value is a command
abuf_acc_new  in  1  1 = start new sum (lane value overwritten, not added)
mac_res  in  BATCH*ACC_W  MAC result; lane i in bits [i*ACC_W +: ACC_W]
rd_en  in  1  drain read request
rd_addr  in  ADDR_W  drain read address
rd_rdy  out  1  drain request accepted this cycle
rd_vld  out  1  rd_data valid
rd_data  out  BATCH*ACC_W  drained entry
busy  out  1  accumulate command in flight

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears the delay line, pipeline, forwarding register, rd_vld, rd_data and busy; rd_rdy therefore reads 1.
  - RAM contents are not cleared; the first touch of any address must use acc_new=1.
  - Reset mid-operation drops all in-flight commands; entries already written keep their values.
- Alignment: an AGU command sampled at edge t is delayed MAC_LAT cycles in a shift register. It enters stage S0 paired with the mac_res sampled at edge t+MAC_LAT.
- S0:
  - A command with acc_en != 0 issues a RAM read of addr (1-cycle registered read).
  - Commands with acc_en == 0 are bubbles: no read, no write.
- S1, one cycle after S0:
  - For each lane i with en[i]=1: new[i] = (acc_new ? 0 : old[i]) + mac[i], truncated to ACC_W (wraps, no saturation).
  - Lanes with en[i]=0 are not written (per-lane write enable).
  - The write commits at the end of S1.
- Forwarding:
  - RAM is read-old-during-write. A forwarding register captures {addr, lane mask, data} of each S1 write.
  - When a command enters S1 and its addr matches the forwarding register, which holds the write committed in the same cycle its S0 read issued, old[i] is replaced by the forwarded data for each lane set in that write's mask.
  - Back-to-back commands to one address accumulate correctly at full rate (1 command/cycle).
- Drain port:
  - rd_rdy = ~(S0 holds an accumulate command); accumulate always has priority.
  - A request is accepted when rd_en & rd_rdy; rd_vld=1 with rd_data exactly 1 cycle later.
  - rd_data holds its value until the next accepted read.
  - If rd_en is not accepted, the requester holds rd_en and rd_addr.
  - Draining while busy=1 returns data that may be stale; the controller drains only after busy=0.
- busy = OR of command valid bits in the delay line, S0 and S1. busy falls the cycle after the last write commits.
- Addresses at or above DEPTH: behaviour undefined; the AGU does not generate them.

Test Plan:
- Reset then idle: busy=0, rd_rdy=1, rd_vld=0, rd_data=0; after rst released, outputs unchanged with no input.
- Single new sum: addr=5, en=4'b1111, new=1, mac lanes {1,2,3,4} → drain addr 5 after busy=0 gives {1,2,3,4}; rd_vld exactly 1 cycle after rd_rdy&rd_en.
- Back-to-back hazard: 4 consecutive commands to addr 7, first new=1, all mac lanes=10 → drain gives 40 per lane.
- Lane masking: addr 3 preset to {5,5,5,5}; command en=4'b0101, new=0, mac {1,1,1,1} → {6,5,6,5}.
- Wrap and arbitration: lane at 0x7FFFFFFF plus 1 → 0x80000000. Drain request in the same cycle as an S0 command → rd_rdy=0 that cycle; accepted the next idle cycle.
- Async reset mid-stream: assert rst between commands 2 and 3 of 4 to addr 9 → busy=0 immediately, rd_vld=0, no further writes to addr 9.
